// File: rtl/imem_if.sv
// Instruction-memory fetch bus.
//   imem_req   : fetch request, held until imem_ack
//   imem_addr  : word address of the fetch, stable while imem_req=1
//   imem_rdata : instruction word, valid when imem_ack=1
//   imem_ack   : one-cycle completion strobe
// master = fetch unit, slave = instruction memory.
interface imem_if #(
  parameter int ADDR_W = 16
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_rdata;
  logic              imem_ack;

  modport master (output imem_req, output imem_addr, input imem_rdata, input imem_ack);
  modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_ack);
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end for the Controller.
// Fetches 16-bit instructions over the imem req/ack bus into an instruction
// register, presents Opcode = IR[15:12], and at retire computes the next PC
// from the Controller's Branch / Branch_not / PC_write and the ALU zero flag.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   imem         : imem_if master (req/addr out, rdata/ack in)
//   Opcode       : IR[15:12]
//   instr        : full instruction register
//   instr_valid  : IR holds the instruction currently being issued
//   stall        : datapath not ready to retire the current instruction
//   Branch, Branch_not, PC_write, zero : next-PC controls, sampled at retire
//   pc           : current PC
module instr_fetch_unit #(
  parameter int              ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  imem_if.master            imem,
  output logic [3:0]        Opcode,
  output logic [15:0]       instr,
  output logic              instr_valid,
  input  logic              stall,
  input  logic              Branch,
  input  logic              Branch_not,
  input  logic              PC_write,
  input  logic              zero,
  output logic [ADDR_W-1:0] pc
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic              req_q, req_d;
  logic              vld_q, vld_d;
  logic              taken;
  logic [ADDR_W-1:0] offset;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    req_d   = req_q;
    vld_d   = vld_q;
    // Both branch bits set resolves to taken regardless of zero.
    taken   = (Branch & zero) | (Branch_not & ~zero);
    offset  = ADDR_W'($signed(ir_q[7:0]));
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        req_d   = 1'b1;
        vld_d   = 1'b0;
      end
      S_FETCH: begin
        if (imem.imem_ack) begin
          ir_d    = imem.imem_rdata;
          state_d = S_ISSUE;
          req_d   = 1'b0;
          vld_d   = 1'b1;
        end
      end
      S_ISSUE: begin
        // ack is ignored here; only a retire moves us on.
        if (!stall) begin
          state_d = S_FETCH;
          req_d   = 1'b1;
          vld_d   = 1'b0;
          if (PC_write)
            pc_d = pc_q + ADDR_W'(1) + (taken ? offset : '0);
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
        vld_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      req_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      req_q   <= req_d;
      vld_q   <= vld_d;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign Opcode         = ir_q[15:12];
  assign instr          = ir_q;
  assign instr_valid    = vld_q;
  assign pc             = pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_if #(.ADDR_W(16)) imem ();

  logic [3:0]  opcode;
  logic [15:0] instr;
  logic        instr_valid;
  logic        stall, branch, branch_not, pc_write, zero;
  logic [15:0] pc;

  instr_fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (imem),
    .Opcode      (opcode),
    .instr       (instr),
    .instr_valid (instr_valid),
    .stall       (stall),
    .Branch      (branch),
    .Branch_not  (branch_not),
    .PC_write    (pc_write),
    .zero        (zero),
    .pc          (pc)
  );

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [15:0] exp_q[$];     // expected fetch addresses, oldest first
  logic [15:0] exp_pc;
  logic [15:0] cur_ir;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Serve one fetch: wait for req, check address against scoreboard,
  // hold off ack for 'waits' cycles, then check the issued instruction.
  task automatic fetch(input logic [15:0] data, input int waits);
    logic [15:0] a;
    int n;
    n = 0;
    while (imem.imem_req !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    chk("req_seen", {31'd0, imem.imem_req}, 32'd1);
    chk("sb_nonempty", exp_q.size(), 32'd1);
    a = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hDEAD;
    chk("imem_addr", imem.imem_addr, a);
    chk("pc_fetch", pc, a);
    chk("valid_in_fetch", {31'd0, instr_valid}, 32'd0);
    for (int w = 0; w < waits; w++) begin
      tick;
      chk("req_stable", {31'd0, imem.imem_req}, 32'd1);
      chk("addr_stable", imem.imem_addr, a);
    end
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = data;
    tick;
    imem.imem_ack   = 1'b0;
    imem.imem_rdata = 16'h5A5A;
    chk("valid_issue", {31'd0, instr_valid}, 32'd1);
    chk("instr", instr, data);
    chk("opcode", opcode, data[15:12]);
    chk("req_drop", {31'd0, imem.imem_req}, 32'd0);
    cur_ir = data;
    exp_pc = a;
  endtask

  // Hold in ISSUE for stall_cyc cycles, then retire with the given controls
  // and push the model's next PC onto the scoreboard.
  task automatic retire(input logic b, input logic bn, input logic pw, input logic z,
                        input int stall_cyc, input logic junk_ack);
    logic        tk;
    logic [15:0] nxt;
    branch = b; branch_not = bn; pc_write = pw; zero = z;
    stall = 1'b1;
    for (int s = 0; s < stall_cyc; s++) begin
      if (junk_ack && s == 0) begin
        imem.imem_ack = 1'b1; imem.imem_rdata = 16'hFFFF;
      end
      tick;
      imem.imem_ack = 1'b0;
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_req", {31'd0, imem.imem_req}, 32'd0);
      chk("stall_pc", pc, exp_pc);
      chk("stall_opcode", opcode, cur_ir[15:12]);
      chk("stall_instr", instr, cur_ir);
    end
    tk  = (b & z) | (bn & ~z);
    nxt = !pw ? exp_pc : (tk ? exp_pc + 16'd1 + {{8{cur_ir[7]}}, cur_ir[7:0]} : exp_pc + 16'd1);
    exp_q.push_back(nxt);
    stall = 1'b0;
    tick;
    stall = 1'b1;
    branch = 1'b0; branch_not = 1'b0; pc_write = 1'b1; zero = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall = 1'b1; branch = 1'b0; branch_not = 1'b0; pc_write = 1'b1; zero = 1'b0;
    imem.imem_ack = 1'b0; imem.imem_rdata = 16'h0000;
    exp_pc = 16'h0; cur_ir = 16'h0;
    tick; tick;
    chk("rst_pc", pc, 16'h0000);
    chk("rst_ir", instr, 16'h0000);
    chk("rst_op", opcode, 4'h0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_req", {31'd0, imem.imem_req}, 32'd0);
    rst = 1'b0;
    // IDLE cycle: ack here must be ignored
    imem.imem_ack = 1'b1; imem.imem_rdata = 16'hEEEE;
    tick;
    imem.imem_ack = 1'b0;
    chk("idle_ack_ignored_valid", {31'd0, instr_valid}, 32'd0);
    chk("req_2nd_cycle", {31'd0, imem.imem_req}, 32'd1);
    exp_q.push_back(16'h0000);

    // sequential fetches 0,1,2 (third with 3 wait states)
    fetch(16'h1234, 0);
    retire(0, 0, 1, 0, 0, 0);
    fetch(16'h2001, 0);
    retire(0, 0, 1, 0, 0, 0);
    fetch(16'h3002, 3);
    retire(1, 0, 1, 1, 0, 0);               // 2+1+2 -> 5
    chk("addr_5", imem.imem_addr, 16'h0005);
    fetch(16'h40FC, 0);
    retire(1, 0, 1, 1, 0, 0);               // 5+1-4 -> 2
    chk("addr_taken_2", imem.imem_addr, 16'h0002);
    fetch(16'h5002, 0);
    retire(1, 0, 1, 1, 0, 0);               // -> 5
    fetch(16'h60FC, 0);
    retire(1, 0, 1, 0, 0, 0);               // not taken -> 6
    chk("addr_nt_6", imem.imem_addr, 16'h0006);
    fetch(16'h70FE, 0);
    retire(0, 1, 1, 0, 0, 0);               // 6+1-2 -> 5
    fetch(16'h8003, 0);
    retire(0, 1, 1, 0, 0, 0);               // 5+1+3 -> 9
    chk("addr_bn_9", imem.imem_addr, 16'h0009);
    fetch(16'h91F6, 0);
    retire(1, 1, 1, 1, 0, 0);               // both set, taken: 9+1-10 -> 0
    chk("addr_both_0", imem.imem_addr, 16'h0000);
    fetch(16'hA0FE, 0);
    retire(1, 1, 1, 0, 0, 0);               // both set, taken: 0+1-2 -> FFFF
    chk("addr_ffff", imem.imem_addr, 16'hFFFF);
    fetch(16'hB0FF, 0);
    retire(1, 0, 1, 0, 4, 1);               // stall 4, junk ack, wrap -> 0
    chk("addr_wrap", imem.imem_addr, 16'h0000);
    fetch(16'hC000, 0);
    retire(0, 0, 0, 0, 0, 0);               // halt -> 0
    fetch(16'hC000, 2);
    retire(1, 0, 0, 1, 0, 0);               // halt overrides branch -> 0
    chk("halt_refetch", imem.imem_addr, 16'h0000);
    chk("halt_req", {31'd0, imem.imem_req}, 32'd1);

    // reset while req=1 with ack in the same cycle
    rst = 1'b1; imem.imem_ack = 1'b1; imem.imem_rdata = 16'hBEEF;
    tick;
    rst = 1'b0; imem.imem_ack = 1'b0;
    chk("mid_rst_pc", pc, 16'h0000);
    chk("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("mid_rst_ir", instr, 16'h0000);
    chk("mid_rst_req", {31'd0, imem.imem_req}, 32'd0);
    exp_q.delete();
    exp_q.push_back(16'h0000);
    fetch(16'hD123, 1);
    retire(0, 0, 1, 0, 0, 0);
    chk("post_rst_addr", imem.imem_addr, 16'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
